add_share_arb: RTL and testbench
================================

ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the adder; fixed at 4 in this revision, so IDs are 2 bits.
REQ-002 Parameter: W, 16, operand and sum width; fixed at 16 to match bka_16_nocout.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req_valid  input  4  per-requester operation request.
REQ-006 Port: req_a  input  64  operand A, requester i in bits [16i+15:16i].
REQ-007 Port: req_b  input  64  operand B, same packing as req_a.
REQ-008 Port: req_cin  input  4  per-requester carry-in.
REQ-009 Port: req_ready  output  4  one-hot-or-zero grant; request i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 Port: rsp_valid  output  1  result register holds a valid result.
REQ-011 Port: rsp_sum  output  16  registered sum.
REQ-012 Port: rsp_id  output  2  index of the requester that owns rsp_sum.
REQ-013 Port: rsp_ready  input  1  consumer accepts the result.
REQ-014 Port: ops_done  output  16  saturating count of completed response handshakes.

Function
REQ-015 The block shall contain exactly one bka_16_nocout instance, fed from a combinational mux selected by the current grant.
REQ-016 Two-state FSM, EMPTY/FULL, encoded directly by rsp_valid.
REQ-017 accept = ~rsp_valid | rsp_ready.
REQ-018 Grant selection: the first i with req_valid[i]=1, searching cyclically from rr_ptr upward (rr_ptr, rr_ptr+1, ... mod 4).
REQ-019 req_ready[i] = accept & (i is the selected requester); all zero when accept=0, when no req_valid is set, or when rst=1.
REQ-020 On the grant handshake, the next-cycle values shall be:
- rsp_valid = 1
- rsp_sum = (req_a[i] + req_b[i] + req_cin[i]) mod 2^16, carry-out discarded
- rsp_id = i
REQ-021 Latency: exactly 1 cycle from accept to rsp_valid.
REQ-022 Throughput: 1 operation per cycle; a result drain (rsp_valid & rsp_ready) and a new grant in the same cycle shall both take effect, with rsp_valid staying 1 and new data loaded.
REQ-023 Drain with no new grant: rsp_valid goes to 0 next cycle.
REQ-024 While FULL and rsp_ready=0, rsp_sum and rsp_id shall hold stable and req_ready shall be 0.
REQ-025 rr_ptr (2-bit, internal) shall update to (i+1) mod 4 on each grant, wrapping 3 -> 0, and hold otherwise.
REQ-026 A requester deasserting req_valid before being granted shall have no effect on state; requesters shall hold operands stable while valid and not ready.
REQ-027 ops_done shall increment on each rsp_valid & rsp_ready cycle and saturate at 0xFFFF (no wrap).
REQ-028 In EMPTY, rsp_sum and rsp_id shall retain their last values, and consumers shall ignore them.

Reset
REQ-029 rst=1 at a clock edge shall set rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, ops_done=0.
REQ-030 A mid-operation rst discards any held result with no handshake counted; req_ready is forced to 0 while rst=1.
REQ-031 First cycle after reset release: grant priority starts at requester 0.

Verification
REQ-032 After reset, req_valid=4'b0001, a=0x1234, b=0x0001, cin=1, rsp_ready=1 -> req_ready=4'b0001; next cycle rsp_valid=1, rsp_sum=0x1236, rsp_id=0.
REQ-033 Single request a=0xFFFF, b=0x0001, cin=1 -> rsp_sum=0x0001 (wrap, carry dropped).
REQ-034 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_valid constant 1, rsp_id sequence 0,1,2,3,0.
REQ-035 rsp_ready=0 for 5 cycles while FULL with 2 valid requesters -> req_ready=0, rsp_sum/rsp_id unchanged; on rsp_ready=1, a new grant occurs the same cycle.
REQ-036 rst asserted while FULL with requests pending -> next cycle rsp_valid=0, ops_done=0, rr_ptr=0; requester 0 is granted first after release.
REQ-037 Force 65,540 handshakes -> ops_done reads 0xFFFF and remains there.

Source files
------------

// File: rtl/add_share_arb_if.sv
// Requester/consumer bundle for add_share_arb: packed per-requester operands in,
// one registered sum out with the owning requester's index.
interface add_share_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*W-1:0]       req_a;
    logic [NREQ*W-1:0]       req_b;
    logic [NREQ-1:0]         req_cin;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic [W-1:0]            rsp_sum;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic                    rsp_ready;
    logic [15:0]             ops_done;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, ops_done
    );
endinterface

// File: rtl/add_share_arb.sv
// One Brent-Kung adder shared round-robin between four requesters, with a single
// registered result slot that drains and refills in the same cycle.
module bka_16_nocout (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] pp;

    // g[i] ends as the carry out of bit i, with cin folded into bit 0.
    always_comb begin
        pp = a_i ^ b_i;
        g  = a_i & b_i;
        p  = pp;
        g[0] = g[0] | (p[0] & cin_i);
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                int j;
                j = (i >= (1 << l)) ? i - (1 << l) : 0;
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < 16; i++) begin
                int j;
                j = (i >= (1 << l)) ? i - (1 << l) : 0;
                if ((i >= (3 * (1 << l)) - 1) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        sum_o = pp ^ {g[14:0], cin_i};
    end
endmodule

module add_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16
) (
    input logic            clk,
    input logic            rst,
    add_share_arb_if.slave bus
);
    typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic [1:0]  id_q, id_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] ops_q, ops_d;

    logic         accept;
    logic         drain;
    logic         gnt_any;
    logic         grant_fire;
    logic [1:0]   gnt_idx;
    logic [1:0]   cand;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [W-1:0] add_sum;

    assign accept = (state_q == StEmpty) | bus.rsp_ready;
    assign drain  = (state_q == StFull) & bus.rsp_ready;

    // Descending scan so the closest requester at or after rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr_q;
        cand    = rr_ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant_fire = accept & gnt_any & ~rst;

    always_comb begin
        bus.req_ready = '0;
        if (grant_fire) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_a   = bus.req_a[gnt_idx * W +: W];
    assign op_b   = bus.req_b[gnt_idx * W +: W];
    assign op_cin = bus.req_cin[gnt_idx];

    bka_16_nocout u_adder (
        .a_i   (op_a),
        .b_i   (op_b),
        .cin_i (op_cin),
        .sum_o (add_sum)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        ops_d    = ops_q;
        if (grant_fire) begin
            state_d  = StFull;
            sum_d    = add_sum;
            id_d     = gnt_idx;
            rr_ptr_d = gnt_idx + 2'd1;
        end else if (drain) begin
            state_d = StEmpty;
        end
        if (drain && (ops_q != 16'hFFFF)) begin
            ops_d = ops_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            sum_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            ops_q    <= ops_d;
        end
    end

    assign bus.rsp_valid = (state_q == StFull);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
    assign bus.ops_done  = ops_q;
endmodule

// File: tb/tb_add_share_arb.sv
// Randomized and directed bench for add_share_arb against a cycle-level behavioural model.
module tb_add_share_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_share_arb_if bus ();

    add_share_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: the one result slot, round-robin pointer and handshake count.
    bit m_valid = 1'b0;
    int m_sum   = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            int g;
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
            end else begin
                g = (!m_valid || bus.rsp_ready) ? pick(bus.req_valid, m_ptr) : -1;
                if (m_valid && bus.rsp_ready && m_cnt < 65535) m_cnt++;
                if (g >= 0) begin
                    m_sum = (int'(bus.req_a[g*16 +: 16]) + int'(bus.req_b[g*16 +: 16])
                             + int'(bus.req_cin[g])) % 65536;
                    m_id    = g;
                    m_ptr   = (g + 1) % 4;
                    m_valid = 1'b1;
                end else if (m_valid && bus.rsp_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            int g;
            logic [3:0] er;
            @(negedge clk);
            if (chk_en) begin
                g  = (rst || (m_valid && !bus.rsp_ready)) ? -1 : pick(bus.req_valid, m_ptr);
                er = (g < 0) ? 4'b0000 : 4'(1 << g);
                chk("req_ready", 32'(bus.req_ready), 32'(er));
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
                chk("rsp_sum", 32'(bus.rsp_sum), m_sum);
                chk("rsp_id", 32'(bus.rsp_id), m_id);
                chk("ops_done", 32'(bus.ops_done), m_cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] vprev;
        logic [3:0] rprev;
        rst = 1'b1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
        bus.rsp_ready = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        probe();
        chk("reset_valid", 32'(bus.rsp_valid), 0);
        chk("reset_sum", 32'(bus.rsp_sum), 0);
        chk("reset_ops", 32'(bus.ops_done), 0);

        // Basic single grant.
        cyc();
        rst = 1'b0;
        bus.req_valid = 4'b0001; bus.req_a[15:0] = 16'h1234; bus.req_b[15:0] = 16'h0001;
        bus.req_cin = 4'b0001; bus.rsp_ready = 1'b1;
        probe();
        chk("basic_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = '0;
        probe();
        chk("basic_valid", 32'(bus.rsp_valid), 1);
        chk("basic_sum", 32'(bus.rsp_sum), 32'h1236);
        chk("basic_id", 32'(bus.rsp_id), 0);

        // Wrap with carry dropped.
        cyc();
        bus.req_valid = 4'b0001; bus.req_a[15:0] = 16'hFFFF; bus.req_b[15:0] = 16'h0001;
        bus.req_cin = 4'b0001;
        cyc();
        bus.req_valid = '0;
        probe();
        chk("wrap_sum", 32'(bus.rsp_sum), 32'h0001);

        // Round robin with all requesters valid.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = 4'b1111; bus.rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            probe();
            if (n < 5) chk("rr_ready", 32'(bus.req_ready), 32'(1 << (n % 4)));
            if (n > 0) begin
                chk("rr_id", 32'(bus.rsp_id), 32'((n - 1) % 4));
                chk("rr_valid", 32'(bus.rsp_valid), 1);
            end
            cyc();
        end

        // Backpressure: slot held, no grants, then refill on release.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = 4'b0011; bus.rsp_ready = 1'b0;
        bus.req_a = {16'h0, 16'h0, 16'h1000, 16'h0100};
        bus.req_b = {16'h0, 16'h0, 16'h0FFF, 16'h0023};
        bus.req_cin = 4'b0010;
        probe();
        chk("bp_first_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        for (int n = 0; n < 5; n++) begin
            probe();
            chk("bp_ready", 32'(bus.req_ready), 0);
            chk("bp_sum", 32'(bus.rsp_sum), 32'h0123);
            chk("bp_id", 32'(bus.rsp_id), 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        probe();
        chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
        cyc();
        probe();
        chk("bp_new_sum", 32'(bus.rsp_sum), 32'h2000);
        chk("bp_new_id", 32'(bus.rsp_id), 1);

        // Reset while full with requests pending.
        cyc();
        rst = 1'b1; bus.req_valid = 4'b1111; bus.rsp_ready = 1'b0;
        probe();
        chk("midrst_ready", 32'(bus.req_ready), 0);
        cyc();
        rst = 1'b0;
        probe();
        chk("midrst_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_ops", 32'(bus.ops_done), 0);
        chk("midrst_first", 32'(bus.req_ready), 32'h1);

        // Randomized traffic; pending requesters hold operands or withdraw.
        repeat (3000) begin
            @(negedge clk);
            vprev = bus.req_valid;
            rprev = bus.req_ready;
            cyc();
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 4; i++) begin
                if (vprev[i] && !rprev[i]) begin
                    if ($urandom_range(0, 9) < 2) bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    bus.req_a[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                    bus.req_b[i*16 +: 16] = 16'($urandom);
                    bus.req_cin[i] = ($urandom_range(0, 1) == 1);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
        end

        // Saturation of the handshake counter.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; bus.req_valid = 4'b0001; bus.rsp_ready = 1'b1;
        repeat (65540) cyc();
        probe();
        chk("sat_ops", 32'(bus.ops_done), 32'hFFFF);
        repeat (3) cyc();
        probe();
        chk("sat_hold", 32'(bus.ops_done), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
